// File: rtl/spm_protect_seq.sv
// Sequencer for the Sancus protect operation: validates a layout, runs the slot overlap check,
// allocates the lowest free slot, commits it with a fresh ID and streams the module key into it.
module spm_protect_seq #(
  parameter int unsigned NB_SPMS      = 4,
  parameter int unsigned KEY_WORDS    = 4,
  parameter int unsigned KEY_IDX_SIZE = 2
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    start,
  input  logic [15:0]             r12,
  input  logic [15:0]             r13,
  input  logic [15:0]             r14,
  input  logic [15:0]             r15,
  input  logic [NB_SPMS-1:0]      slot_enabled,
  input  logic                    violation_any,
  input  logic [15:0]             key_word,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic [15:0]             cfg_r12,
  output logic [15:0]             cfg_r13,
  output logic [15:0]             cfg_r14,
  output logic [15:0]             cfg_r15,
  output logic                    check_new_spm,
  output logic [NB_SPMS-1:0]      update_spm,
  output logic                    enable_spm,
  output logic [15:0]             next_id,
  output logic [15:0]             spm_key_select,
  output logic                    write_key,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic [15:0]             key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code
);

  typedef enum logic [2:0] {StIdle, StCheck, StAlloc, StKey, StDone} state_e;

  state_e                  state_q;
  logic [15:0]             cfg_r12_q, cfg_r13_q, cfg_r14_q, cfg_r15_q;
  logic [NB_SPMS-1:0]      slot_oh_q;
  logic [KEY_IDX_SIZE-1:0] word_cnt_q;
  logic [15:0]             next_id_q, next_id_d;
  logic                    error_q;
  logic [1:0]              err_code_q;

  logic [NB_SPMS-1:0] free_slots;
  logic [NB_SPMS-1:0] lowest_free;
  logic               layout_bad;
  logic               last_word;

  assign free_slots  = ~slot_enabled;
  // Two's-complement trick isolates the lowest set bit as a one-hot slot select.
  assign lowest_free = free_slots & (~free_slots + NB_SPMS'(1));
  assign layout_bad  = (r12 >= r13) | (r14 > r15);
  assign last_word   = (word_cnt_q == KEY_IDX_SIZE'(KEY_WORDS - 1));

  // ID 0 means "no module", so the counter skips it on wrap.
  always_comb begin
    next_id_d = next_id_q;
    if (state_q == StAlloc) begin
      next_id_d = (next_id_q == 16'hFFFF) ? 16'h0001 : next_id_q + 16'd1;
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q    <= StIdle;
      cfg_r12_q  <= '0;
      cfg_r13_q  <= '0;
      cfg_r14_q  <= '0;
      cfg_r15_q  <= '0;
      slot_oh_q  <= '0;
      word_cnt_q <= '0;
      next_id_q  <= 16'h0001;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      error_q   <= 1'b0;
      next_id_q <= next_id_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cfg_r12_q <= r12;
            cfg_r13_q <= r13;
            cfg_r14_q <= r14;
            cfg_r15_q <= r15;
            if (layout_bad) begin
              error_q    <= 1'b1;
              err_code_q <= 2'd1;
            end else begin
              err_code_q <= 2'd0;
              state_q    <= StCheck;
            end
          end
        end
        StCheck: begin
          if (violation_any) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd2;
            state_q    <= StIdle;
          end else if (&slot_enabled) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd3;
            state_q    <= StIdle;
          end else begin
            slot_oh_q <= lowest_free;
            state_q   <= StAlloc;
          end
        end
        StAlloc: begin
          word_cnt_q <= '0;
          state_q    <= StKey;
        end
        StKey: begin
          if (key_valid) begin
            if (last_word) begin
              word_cnt_q <= '0;
              state_q    <= StDone;
            end else begin
              word_cnt_q <= word_cnt_q + KEY_IDX_SIZE'(1);
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = (state_q != StIdle);
  assign check_new_spm  = (state_q == StCheck);
  assign enable_spm     = (state_q == StAlloc);
  assign update_spm     = enable_spm ? slot_oh_q : '0;
  assign key_ready      = (state_q == StKey);
  assign done           = (state_q == StDone);
  assign write_key      = key_valid & key_ready;
  assign key_idx        = word_cnt_q;
  assign key_in         = key_word;
  assign spm_key_select = cfg_r12_q;
  assign cfg_r12        = cfg_r12_q;
  assign cfg_r13        = cfg_r13_q;
  assign cfg_r14        = cfg_r14_q;
  assign cfg_r15        = cfg_r15_q;
  assign next_id        = next_id_q;
  assign error          = error_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_spm_protect_seq.sv
// Randomized bench for spm_protect_seq; a request-level model predicts the outcome, the chosen
// slot, the committed ID and the cycle-by-cycle key stream.
module tb_spm_protect_seq;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        start;
  logic [15:0] r12, r13, r14, r15;
  logic [3:0]  slot_enabled;
  logic        violation_any;
  logic [15:0] key_word;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] cfg_r12, cfg_r13, cfg_r14, cfg_r15;
  logic        check_new_spm;
  logic [3:0]  update_spm;
  logic        enable_spm;
  logic [15:0] next_id;
  logic [15:0] spm_key_select;
  logic        write_key;
  logic [1:0]  key_idx;
  logic [15:0] key_in;
  logic        busy, done, error;
  logic [1:0]  err_code;

  spm_protect_seq #(
    .NB_SPMS     (4),
    .KEY_WORDS   (4),
    .KEY_IDX_SIZE(2)
  ) dut (
    .mclk          (mclk),
    .puc_rst       (puc_rst),
    .start         (start),
    .r12           (r12),
    .r13           (r13),
    .r14           (r14),
    .r15           (r15),
    .slot_enabled  (slot_enabled),
    .violation_any (violation_any),
    .key_word      (key_word),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .cfg_r12       (cfg_r12),
    .cfg_r13       (cfg_r13),
    .cfg_r14       (cfg_r14),
    .cfg_r15       (cfg_r15),
    .check_new_spm (check_new_spm),
    .update_spm    (update_spm),
    .enable_spm    (enable_spm),
    .next_id       (next_id),
    .spm_key_select(spm_key_select),
    .write_key     (write_key),
    .key_idx       (key_idx),
    .key_in        (key_in),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code)
  );

  always #5 mclk = ~mclk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_id;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // mode 0: key_valid always 1; mode 1: pattern 1,0,0,1,1,0,1; mode 2: random with busy-start noise
  task automatic run_protect(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                             input logic [15:0] d, input logic [3:0] slots, input logic viol,
                             input int mode);
    int         exp_err;
    logic [3:0] exp_oh;
    logic [6:0] pat;
    logic       kv;
    int         acc;
    int         cyc;
    pat     = 7'b1011001;
    exp_err = 0;
    exp_oh  = 4'b0000;
    if (a >= b || c > d)   exp_err = 1;
    else if (viol)         exp_err = 2;
    else if (slots == 4'hF) exp_err = 3;
    else begin
      for (int i = 3; i >= 0; i--) if (!slots[i]) exp_oh = 4'(1 << i);
    end

    // cycle 0: request
    start = 1'b1; r12 = a; r13 = b; r14 = c; r15 = d;
    slot_enabled = slots; violation_any = viol; key_valid = 1'($urandom);
    @(negedge mclk);
    check_eq("idle_busy", busy, 0);
    step();
    start = 1'b0;
    key_valid = 1'($urandom);

    // cycle 1
    @(negedge mclk);
    if (exp_err == 1) begin
      check_eq("bad_layout_error", error, 1);
      check_eq("bad_layout_code", err_code, 1);
      check_eq("bad_layout_busy", busy, 0);
      check_eq("bad_layout_check", check_new_spm, 0);
      step();
      return;
    end
    check_eq("check_strobe", check_new_spm, 1);
    check_eq("check_busy", busy, 1);
    check_eq("check_key_ready", key_ready, 0);
    check_eq("check_write_key", write_key, 0);
    check_eq("check_cfg_r15", cfg_r15, d);
    step();
    key_valid = 1'($urandom);

    // cycle 2
    @(negedge mclk);
    if (exp_err != 0) begin
      check_eq("fail_error", error, 1);
      check_eq("fail_code", err_code, exp_err);
      check_eq("fail_update", update_spm, 0);
      check_eq("fail_busy", busy, 0);
      check_eq("fail_next_id", next_id, model_id);
      step();
      return;
    end
    check_eq("alloc_update", update_spm, exp_oh);
    check_eq("alloc_enable", enable_spm, 1);
    check_eq("alloc_next_id", next_id, model_id);
    check_eq("alloc_write_key", write_key, 0);
    model_id = (model_id == 16'hFFFF) ? 16'h0001 : model_id + 16'd1;
    step();

    // key phase
    acc = 0;
    cyc = 0;
    while (acc < 4 && cyc < 64) begin
      if (mode == 0)      kv = 1'b1;
      else if (mode == 1) kv = (cyc < 7) ? pat[cyc] : 1'b1;
      else                kv = 1'($urandom);
      key_valid = kv;
      key_word  = 16'($urandom);
      if (mode == 2) begin
        start = 1'($urandom);
        r12   = 16'($urandom);
      end
      @(negedge mclk);
      check_eq("key_ready", key_ready, 1);
      check_eq("key_write", write_key, kv);
      check_eq("key_idx", key_idx, acc);
      check_eq("key_in", key_in, key_word);
      check_eq("key_select", spm_key_select, a);
      if (kv) acc++;
      cyc++;
      step();
    end
    if (acc < 4) check_eq("key_timeout", 0, 1);
    start = 1'b0;
    key_valid = 1'($urandom);
    @(negedge mclk);
    check_eq("done_pulse", done, 1);
    check_eq("done_write_key", write_key, 0);
    step();
    @(negedge mclk);
    check_eq("after_busy", busy, 0);
    check_eq("after_done", done, 0);
    check_eq("after_next_id", next_id, model_id);
    check_eq("after_err_code", err_code, 0);
    step();
  endtask

  initial begin
    logic [15:0] a, b, c, d;
    puc_rst = 1'b1;
    start = 1'b0; r12 = '0; r13 = '0; r14 = '0; r15 = '0;
    slot_enabled = '0; violation_any = 1'b0; key_word = 16'h1234; key_valid = 1'b1;
    model_id = 16'h0001;
    @(negedge mclk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_check", check_new_spm, 0);
    check_eq("rst_update", update_spm, 0);
    check_eq("rst_enable", enable_spm, 0);
    check_eq("rst_write_key", write_key, 0);
    check_eq("rst_key_ready", key_ready, 0);
    check_eq("rst_key_idx", key_idx, 0);
    check_eq("rst_next_id", next_id, 16'h0001);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_cfg_r12", cfg_r12, 0);
    puc_rst = 1'b0;
    step();

    run_protect(16'h8000, 16'h8100, 16'h0300, 16'h0310, 4'b0000, 1'b0, 0);
    run_protect(16'h9000, 16'h9000, 16'h0300, 16'h0310, 4'b0000, 1'b0, 0);
    @(negedge mclk);
    check_eq("err_code_hold", err_code, 1);
    step();
    run_protect(16'h0100, 16'h0200, 16'h0400, 16'h0300, 4'b0000, 1'b0, 0);
    run_protect(16'h8000, 16'h8100, 16'h0300, 16'h0310, 4'b0000, 1'b1, 0);
    run_protect(16'h8000, 16'h8100, 16'h0300, 16'h0310, 4'b1011, 1'b0, 0);
    run_protect(16'h8000, 16'h8100, 16'h0300, 16'h0310, 4'b1111, 1'b0, 0);
    run_protect(16'h1000, 16'h2000, 16'h3000, 16'h3000, 4'b0001, 1'b0, 1);

    // ID wrap
    force dut.next_id_q = 16'hFFFF;
    step();
    release dut.next_id_q;
    model_id = 16'hFFFF;
    @(negedge mclk);
    check_eq("forced_next_id", next_id, 16'hFFFF);
    step();
    run_protect(16'h4000, 16'h4800, 16'h5000, 16'h5100, 4'b0011, 1'b0, 0);

    // Reset while streaming the key
    start = 1'b1; r12 = 16'h6000; r13 = 16'h6100; r14 = 16'h0000; r15 = 16'h0010;
    slot_enabled = 4'b0000; violation_any = 1'b0; key_valid = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    @(negedge mclk);
    check_eq("pre_rst_in_key", key_ready, 1);
    step();
    puc_rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_next_id", next_id, 16'h0001);
    check_eq("midrst_key_ready", key_ready, 0);
    @(negedge mclk);
    puc_rst = 1'b0;
    model_id = 16'h0001;
    step();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      end else begin
        a = 16'($urandom_range(0, 16'hFFFE));
        b = 16'($urandom_range(32'(a) + 1, 16'hFFFF));
        c = 16'($urandom);
        d = 16'($urandom_range(32'(c), 16'hFFFF));
      end
      run_protect(a, b, c, d, 4'($urandom), ($urandom_range(0, 3) == 0), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spm_protect_seq.md
# spm_protect_seq

Sequencer for the Sancus `protect` operation. It sits between the CPU execution unit and the array of protected-module slots, and runs one protect request at a time. For each request it validates the layout, runs the one-cycle overlap check across all slots and allocates the lowest free slot. It then commits the layout with a fresh module ID and streams the derived module key into that slot one 16-bit word at a time.

## Interface
Parameters:
- NB_SPMS, 4, number of module slots.
- KEY_WORDS, 4, 16-bit words per module key (`SECURITY/16).
- KEY_IDX_SIZE, 2, width of key_idx; must be at least clog2(KEY_WORDS).

Ports:
- mclk  in  1  clock.
- puc_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle protect request; r12..r15 are valid in the same cycle.
- r12, r13, r14, r15  in  16 each  public start/end, secret start/end.
- slot_enabled  in  NB_SPMS  enabled flag of each slot.
- violation_any  in  1  OR of all slot violation outputs.
- key_word  in  16  key word from the key derivation unit.
- key_valid  in  1  key_word is valid.
- key_ready  out  1  sequencer accepts a key word.
- cfg_r12, cfg_r13, cfg_r14, cfg_r15  out  16 each  latched layout, routed to every slot's r12..r15.
- check_new_spm  out  1  overlap-check strobe to all slots.
- update_spm  out  NB_SPMS  one-hot commit strobe, one bit per slot.
- enable_spm  out  1  qualifies update_spm as an enable.
- next_id  out  16  ID given to the next committed module.
- spm_key_select  out  16  selects the slot that receives the key; equals cfg_r12.
- write_key  out  1  key write strobe.
- key_idx  out  KEY_IDX_SIZE  index of the key word being written.
- key_in  out  16  key word being written.
- busy  out  1  a request is in progress.
- done  out  1  one-cycle success pulse.
- error  out  1  one-cycle failure pulse.
- err_code  out  2  failure cause: 0 none, 1 invalid layout, 2 overlap, 3 no free slot.

## Operation
- FSM states: IDLE, CHECK, ALLOC, KEY, DONE. busy = (state != IDLE).
- IDLE, start=1:
  - Latch r12..r15 into cfg_r12..cfg_r15.
  - If r12 >= r13 or r14 > r15 (unsigned compare): assert error and set err_code=1 in the next cycle; stay in IDLE.
  - Otherwise clear err_code and go to CHECK.
- start while busy is ignored.
- CHECK (exactly 1 cycle): check_new_spm=1; violation_any is sampled in this cycle.
  - violation_any=1 -> err_code=2, error pulse, go to IDLE.
  - Else, if every slot_enabled bit is 1 -> err_code=3, error pulse, go to IDLE.
  - Else latch slot = lowest index with slot_enabled=0, and go to ALLOC.
- ALLOC (1 cycle): update_spm[slot]=1, enable_spm=1. next_id holds the value the slot stores. At the end of the cycle next_id increments; 16'hFFFF wraps to 16'h0001 (ID 0 is reserved for "none"). Go to KEY with the word counter at 0.
- KEY:
  - key_ready=1, spm_key_select=cfg_r12.
  - write_key = key_valid & key_ready (combinational), key_in=key_word, key_idx=word counter.
  - On each accepted word the counter increments. Acceptance of word KEY_WORDS-1 moves to DONE.
- DONE (1 cycle): done=1, then IDLE.
- key_valid outside KEY is ignored; key_ready=0 outside KEY.
- err_code holds its value until the next accepted start.

## Timing
- Reset values:
  - state=IDLE, next_id=16'h0001, err_code=0, cfg_r*=0.
  - busy, done, error, check_new_spm, update_spm, enable_spm, write_key, key_ready all 0; key_idx=0.
- check_new_spm, update_spm, enable_spm, key_ready, done and busy decode directly from registered state; they are glitch-free.
- error is a registered one-cycle pulse: the cycle after start for err_code 1, the cycle after CHECK for codes 2 and 3. It coincides with state=IDLE.
- Minimum success latency, with start in cycle 0 and key_valid held at 1:
  - CHECK in cycle 1, ALLOC in cycle 2.
  - Key writes in cycles 3..3+KEY_WORDS-1.
  - done in cycle 3+KEY_WORDS (cycle 7 for defaults).
- key_valid stalls extend KEY only; there is no timeout.
- Reset mid-operation: return to IDLE immediately and clear next_id to 1. A partially written key is left in the slot; the slot's own reset clears it.

## Test plan
- Valid layout 0x8000/0x8100/0x0300/0x0310, all slots free, key_valid=1, key words 0x1111..0x4444 -> check_new_spm in cycle 1; update_spm=4'b0001 with next_id=1 in cycle 2; write_key for key_idx 0..3 carrying 0x1111..0x4444 in cycles 3..6; done in cycle 7; next_id=2 afterwards.
- r12=0x9000, r13=0x9000 -> error one cycle later, err_code=1, busy never asserted, no check_new_spm.
- violation_any=1 during CHECK -> error, err_code=2, update_spm stays 0, next_id unchanged.
- slot_enabled=4'b1011 -> update_spm=4'b0100; slot_enabled=4'b1111 -> err_code=3.
- key_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes with consecutive key_idx values; done one cycle after the 4th accepted word.
- Force next_id=0xFFFF, complete a protect -> committed ID 0xFFFF, next_id becomes 0x0001. Assert puc_rst in KEY -> next cycle state IDLE, busy=0, next_id=1.
